decode: RTL and testbench
=========================

// Module: decode
// PURPOSE
// - Instruction-decode stage of the 32-bit single-cycle MIPS datapath, between fetch and execute.
// - Holds the 32x32 general-purpose register file and reads the rs/rt operands.
// - Writes back wr_data to rd (R-type) or rt (I-type), selected by RegDst.
// - Produces the sign-extended 16-bit immediate.
// PARAMETERS
// - none (widths fixed: 32-bit data, 32 registers, 5-bit register addresses)
// PORTS
// clk          in   1   rising-edge clock; only clock in the block
// reset        in   1   synchronous, active-high reset
// instruction  in   32  current instruction word
// wr_data      in   32  write-back data
// RegDst       in   1   write-address select: 1 = rd instr[15:11], 0 = rt instr[20:16]
// RegWrite     in   1   register-file write enable
// rd_out1      out  32  data of register rs = instr[25:21]
// rd_out2      out  32  data of register rt = instr[20:16]
// sign_extend  out  32  {{16{instr[15]}}, instr[15:0]}
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset at posedge clk with reset=1: registers 0..31 cleared to 0; no write that cycle even if RegWrite=1.
// - After reset, rd_out1 and rd_out2 read 0 for every address.
// - Reads are combinational, with zero latency from instruction or register contents:
//   - rd_out1 = regs[instr[25:21]]
//   - rd_out2 = regs[instr[20:16]]
// - Write address: wa = RegDst ? instr[15:11] : instr[20:16].
// - Write timing:
//   - At posedge clk with reset=0 and RegWrite=1: regs[wa] <= wr_data.
//   - RegWrite=0: register file unchanged.
// - Register $0 is hardwired to 0:
//   - Writes with wa=0 are discarded.
//   - Reads of address 0 always return 0.
// - Read-during-write bypass:
//   - If RegWrite=1, reset=0, wa!=0 and a read address equals wa, that read port outputs wr_data combinationally.
//   - The register is updated at the next edge.
//   - Both ports may bypass at once when rs==rt==wa.
// - sign_extend is purely combinational. Bits 31:16 replicate instr[15]; bits 15:0 = instr[15:0].
// - Opcode/funct fields are ignored here; control comes from outside.
// - X/undriven wr_data is written as-is when RegWrite=1. Benches drive wr_data before asserting RegWrite.
// - Reset takes priority over a simultaneous write.
// - Reset mid-operation clears all registers on that edge.
// TESTING
// - Reset sequence:
//   - Stimulus: reset=1 for 1 cycle, then instr=0x8426C140.
//   - Required: rd_out1=0, rd_out2=0, sign_extend=0xFFFFC140.
// - R-type write:
//   - Stimulus: instr=0x8426C140 (rs=1, rt=6, rd=24), RegDst=1, RegWrite=1, wr_data=11, one posedge.
//   - Required: reg24=11, reg6 unchanged (0).
//   - Check: instr with rs=24 gives rd_out1=11.
// - I-type write with positive immediate:
//   - Stimulus: instr=0x84622140 (rs=3, rt=2, rd=4), RegDst=0, RegWrite=1, wr_data=0xDEADBEEF, one edge.
//   - Required: rd_out2=0xDEADBEEF, reg4 still 0, sign_extend=0x00002140.
// - Write disabled:
//   - Stimulus: RegWrite=0, wr_data=0x12345678, several edges.
//   - Required: no register changes.
// - $0 and bypass:
//   - Write 0x55 with wa=0 -> reads of $0 return 0.
//   - Stimulus: rs=rt=wa=7, RegWrite=1, wr_data=0xA5A5A5A5.
//   - Required: both outputs show 0xA5A5A5A5 before the edge.
// - Reset versus write:
//   - Stimulus: reset=1 and RegWrite=1 on the same edge.
//   - Required: all registers read 0 afterwards.

Source files
------------

// File: rtl/decode.sv
// Instruction-decode stage: 32x32 register file with combinational rs/rt reads,
// write-back to rd or rt, read-during-write bypass, and 16-bit immediate sign extension.
module decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] wr_data,
  input  logic        RegDst,
  input  logic        RegWrite,
  output logic [31:0] rd_out1,
  output logic [31:0] rd_out2,
  output logic [31:0] sign_extend
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [4:0] rs_addr;
  logic [4:0] rt_addr;
  logic [4:0] rd_addr;
  logic [4:0] wr_addr;
  logic       wr_en;

  // Opcode and funct are decoded by the external control unit.
  logic unused_ctrl_fields;
  assign unused_ctrl_fields = ^{instruction[31:26], instruction[10:0]};

  assign rs_addr = instruction[25:21];
  assign rt_addr = instruction[20:16];
  assign rd_addr = instruction[15:11];

  always_comb begin
    wr_addr = RegDst ? rd_addr : rt_addr;
    // A write only takes effect outside reset and never to $0.
    wr_en   = RegWrite && !reset && (wr_addr != 5'd0);
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_d[i] = 32'd0;
      end
    end else if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    if (rs_addr == 5'd0) begin
      rd_out1 = 32'd0;
    end else if (wr_en && (rs_addr == wr_addr)) begin
      rd_out1 = wr_data;
    end else begin
      rd_out1 = regs_q[rs_addr];
    end
  end

  always_comb begin
    if (rt_addr == 5'd0) begin
      rd_out2 = 32'd0;
    end else if (wr_en && (rt_addr == wr_addr)) begin
      rd_out2 = wr_data;
    end else begin
      rd_out2 = regs_q[rt_addr];
    end
  end

  assign sign_extend = {{16{instruction[15]}}, instruction[15:0]};

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: directed spec cases then randomized traffic checked
// against an array-based register-file model.
module tb_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] wr_data;
  logic        RegDst;
  logic        RegWrite;
  logic [31:0] rd_out1;
  logic [31:0] rd_out2;
  logic [31:0] sign_extend;

  decode dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .wr_data     (wr_data),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .rd_out1     (rd_out1),
    .rd_out2     (rd_out2),
    .sign_extend (sign_extend)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ese;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mregs[32];
  int          total = 0;
  int          bad   = 0;

  // Reference read: $0 is zero, a live write to the same address is forwarded.
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic [31:0] instr,
                                             input logic [31:0] wd, input logic rdst,
                                             input logic rw, input logic rst);
    logic [4:0] wa;
    wa = rdst ? instr[15:11] : instr[20:16];
    if (a == 5'd0) return 32'd0;
    if (rw && !rst && wa != 5'd0 && a == wa) return wd;
    return mregs[a];
  endfunction

  // Drive one cycle's inputs (called just after a posedge), queue the expectation,
  // then advance past the next posedge and apply the same edge to the model.
  task automatic step(input logic [31:0] instr, input logic [31:0] wd, input logic rdst,
                      input logic rw, input logic rst, input bit chk, input bit lit,
                      input logic [31:0] l1, input logic [31:0] l2, input string name);
    exp_t       e;
    logic [4:0] wa;
    logic [31:0] imm;
    instruction = instr;
    wr_data     = wd;
    RegDst      = rdst;
    RegWrite    = rw;
    reset       = rst;
    imm         = {16'd0, instr[15:0]};
    if (instr[15]) imm = imm - 32'h0001_0000;
    if (chk) begin
      e.name = name;
      e.ese  = imm;
      if (lit) begin
        e.e1 = l1;
        e.e2 = l2;
      end else begin
        e.e1 = model_read(instr[25:21], instr, wd, rdst, rw, rst);
        e.e2 = model_read(instr[20:16], instr, wd, rdst, rw, rst);
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
    wa = rdst ? instr[15:11] : instr[20:16];
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (rw && wa != 5'd0) begin
      mregs[wa] = wd;
    end
    #1;
  endtask

  task automatic dchk(input logic [31:0] instr, input logic [31:0] wd, input logic rdst,
                      input logic rw, input logic rst, input logic [31:0] l1,
                      input logic [31:0] l2, input string name);
    step(instr, wd, rdst, rw, rst, 1'b1, 1'b1, l1, l2, name);
  endtask

  // Monitor: outputs are stable mid-cycle, compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (rd_out1 !== e.e1) begin
          bad++;
          $display("FAIL %s rd_out1 got=%h want=%h", e.name, rd_out1, e.e1);
        end
        total++;
        if (rd_out2 !== e.e2) begin
          bad++;
          $display("FAIL %s rd_out2 got=%h want=%h", e.name, rd_out2, e.e2);
        end
        total++;
        if (sign_extend !== e.ese) begin
          bad++;
          $display("FAIL %s sign_extend got=%h want=%h", e.name, sign_extend, e.ese);
        end
      end
    end
  end

  initial begin
    logic [31:0] instr;
    logic [31:0] wd;
    logic        rdst;
    logic        rw;
    logic        rst;
    int          waits;
    reset       = 1'b1;
    instruction = 32'd0;
    wr_data     = 32'd0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    @(posedge clk);
    #1;

    step(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, "init_reset");
    dchk(32'h8426C140, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "reset_seq");

    // R-type: rs=1 rt=6 rd=24
    dchk(32'h8426C140, 32'd11, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, "rtype_wr");
    dchk(32'h03060000, 32'd0, 1'b0, 1'b0, 1'b0, 32'd11, 32'd0, "rtype_rd");

    // I-type: rs=3 rt=2, rt port forwards during the write cycle
    dchk(32'h84622140, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'd0, 32'hDEADBEEF, "itype_byp");
    dchk(32'h84622140, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'hDEADBEEF, "itype_rd");
    dchk(32'h00820000, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'hDEADBEEF, "reg4_zero");

    for (int i = 0; i < 3; i++) begin
      dchk(32'h03020000, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'd11, 32'hDEADBEEF, "wr_dis");
    end

    dchk(32'h00000000, 32'h55, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, "zero_wr");
    dchk(32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, "zero_rd");

    // rs=rt=rd=7: both ports forward
    dchk(32'h00E73800, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, "dual_byp");
    dchk(32'h00E73800, 32'h0, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, "dual_rd");

    // Reset wins over a same-edge write; no forwarding while reset is high.
    dchk(32'h00E73800, 32'h77, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, "rst_wr_pre");
    for (int i = 0; i < 32; i++) begin
      instr = 32'd0;
      instr[25:21] = i[4:0];
      instr[20:16] = 5'(31 - i);
      dchk(instr, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "rst_clr");
    end

    // Randomized traffic, addresses biased to a few registers to provoke forwarding.
    for (int n = 0; n < 500; n++) begin
      instr = $urandom;
      if ($urandom_range(1, 0) == 0) begin
        instr[25:21] = 5'($urandom_range(3, 0));
        instr[20:16] = 5'($urandom_range(3, 0));
        instr[15:11] = 5'($urandom_range(3, 0));
      end
      wd   = $urandom;
      rdst = 1'($urandom_range(1, 0));
      rw   = ($urandom_range(9, 0) < 6);
      rst  = ($urandom_range(49, 0) == 0);
      step(instr, wd, rdst, rw, rst, 1'b1, 1'b0, 32'd0, 32'd0, "random");
    end

    waits = 0;
    while (sb_q.size() > 0 && waits < 5) begin
      @(negedge clk);
      waits++;
    end
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
